// File: rtl/mult32_seq.sv
// Purpose : sequential shift-and-add unsigned multiplier, WIDTH x WIDTH -> 2*WIDTH.
// Latency : WIDTH steps after the accepting edge. With MULT_EARLY_TERM_EN the run
//           ends once no multiplier bits remain. done then pulses for one cycle.
// Backpressure: start is accepted only while ready=1. Requests while busy or done are dropped.
//
// Ports:
//   clk     - rising-edge clock
//   rst_n   - asynchronous active-low reset (aborts any operation, clears product)
//   start   - operation request, sampled only while ready=1
//   a, b    - multiplicand / multiplier, captured on the accepting edge
//   ready   - high in IDLE only
//   busy    - high in RUN only
//   done    - one-cycle pulse, product valid in the same cycle
//   product - registered result, held until the next completion
//
// Optional build macro: MULT_EARLY_TERM_EN (early termination when multiplier is exhausted)

module mult32_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q,   state_d;
  logic [WIDTH-1:0]     mcand_q,   mcand_d;
  logic [WIDTH-1:0]     mplr_q,    mplr_d;
  logic [WIDTH:0]       acc_hi_q,  acc_hi_d;
  logic [WIDTH-1:0]     acc_lo_q,  acc_lo_d;
  logic [CW-1:0]        cnt_q,     cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;

  // Datapath for one step
  logic [WIDTH-1:0]     addend;
  logic [WIDTH:0]       sum;     // {carry, sum}
  logic [2*WIDTH:0]     step;    // {carry, sum, acc_lo} shifted right by one

`ifdef MULT_EARLY_TERM_EN
  logic [CW:0]          shamt;
`endif

  always_comb begin
    addend = mplr_q[0] ? mcand_q : '0;
    // acc_hi[WIDTH] is always zero after a shift, so adding the full
    // acc_hi is the same as adding its low WIDTH bits.
    sum    = acc_hi_q + {1'b0, addend};
    step   = {sum, acc_lo_q} >> 1;
  end

`ifdef MULT_EARLY_TERM_EN
  // After cnt steps the partial product sits in the top bits of the
  // accumulator, aligned WIDTH-cnt places too high.
  always_comb begin
    shamt = (CW+1)'(WIDTH) - {1'b0, cnt_q};
  end
`endif

  always_comb begin
    state_d   = state_q;
    mcand_d   = mcand_q;
    mplr_d    = mplr_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a;
          mplr_d   = b;
          acc_hi_d = '0;
          acc_lo_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end

      ST_RUN: begin
`ifdef MULT_EARLY_TERM_EN
        if (mplr_q == '0) begin
          product_d = {acc_hi_q[WIDTH-1:0], acc_lo_q} >> shamt;
          state_d   = ST_DONE;
        end else
`endif
        begin
          acc_hi_d = step[2*WIDTH:WIDTH];
          acc_lo_d = step[WIDTH-1:0];
          mplr_d   = mplr_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          // Final step: publish the post-step accumulator in the same edge.
          if (cnt_q == CW'(WIDTH-1)) begin
            product_d = step[2*WIDTH-1:0];
            state_d   = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mcand_q   <= '0;
      mplr_q    <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      mcand_q   <= mcand_d;
      mplr_q    <= mplr_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign ready   = (state_q == ST_IDLE);
  assign busy    = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign product = product_q;

endmodule

// File: tb/tb_mult32_seq.sv
// Purpose : directed self-checking bench for mult32_seq.
// Latency : expected done latency is 32 edges, or the early-termination value when built with it.
// Backpressure: exercises ignored starts while busy/done and held-start back-to-back operation.

module tb_mult32_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        ready;
  logic        busy;
  logic        done;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  mult32_seq #(.WIDTH(32)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && done) done_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  // Expected edges from acceptance to done.
  function automatic int exp_lat(input logic [31:0] bv);
`ifdef MULT_EARLY_TERM_EN
    int m = -1;
    for (int i = 0; i < 32; i++) if (bv[i]) m = i;
    if (m < 0) return 1;
    return (m + 2 > 32) ? 32 : m + 2;
`else
    return 32;
`endif
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!ready) check({tag, "_ready_timeout"}, 64'(ready), 64'd1);
  endtask

  // Launch one operation with a one-cycle start pulse. If ign_at >= 0 a
  // stray start (a=7, b=9) is injected while the operation is running.
  task automatic run_op(input logic [31:0] ia, input logic [31:0] ib,
                        input logic [63:0] exp_p, input bit inject, input string tag);
    int lat;
    int lmax;
    int ign_at;
    bit seen;
    lmax   = exp_lat(ib);
    ign_at = inject ? ((lmax > 10) ? 10 : lmax - 1) : -1;
    wait_ready(tag);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~ia; b = ~ib;
    lat = 0; seen = 1'b0;
    while (!seen && lat < 100) begin
      if (lat == ign_at) begin
        start = 1'b1; a = 32'd7; b = 32'd9;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
      if (lat == 1 && lmax > 1) begin
        check({tag, "_busy"}, 64'(busy), 64'd1);
        check({tag, "_ready_low"}, 64'(ready), 64'd0);
      end
      seen = done;
    end
    start = 1'b0;
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(lmax));
    check({tag, "_product"}, product, exp_p);
    @(posedge clk); #1;
    check({tag, "_done_1cyc"}, 64'(done), 64'd0);
    check({tag, "_ready_back"}, 64'(ready), 64'd1);
    check({tag, "_product_hold"}, product, exp_p);
  endtask

  // Back-to-back vectors with start held high (hand-computed products).
  localparam int NB = 6;
  logic [31:0] pa [NB] = '{32'd1, 32'h80000000, 32'hFFFFFFFF, 32'h00010000, 32'd1000, 32'h80000000};
  logic [31:0] pb [NB] = '{32'd1, 32'd2,         32'd2,         32'h00010000, 32'd1000, 32'h80000000};
  logic [63:0] pp [NB] = '{64'd1, 64'h100000000, 64'h1FFFFFFFE, 64'h100000000, 64'd1000000,
                           64'h4000000000000000};

  initial begin
    int d0;
    int n;
    bit seen;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    #12;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_product", product, 64'd0);
    @(negedge clk); rst_n = 1'b1;

    run_op(32'd3, 32'd5, 64'h000000000000000F, 1'b0, "small");
    run_op(32'hFFFFFFFF, 32'hFFFFFFFF, 64'hFFFFFFFE00000001, 1'b0, "max");
    run_op(32'h12345678, 32'd0, 64'd0, 1'b0, "zero_b");
    run_op(32'd2, 32'd3, 64'd6, 1'b1, "ignore_start");

    // Held start: each pair accepted at the first ready edge, one done each.
    d0 = done_cnt;
    start = 1'b1;
    for (int i = 0; i < NB; i++) begin
      a = pa[i]; b = pb[i];
      wait_ready($sformatf("b2b%0d", i));
      @(posedge clk); #1;
      a = ~pa[i]; b = ~pb[i];
      n = 0; seen = 1'b0;
      while (!seen && n < 100) begin
        @(posedge clk); #1;
        n++;
        seen = done;
      end
      check($sformatf("b2b%0d_done_seen", i), 64'(seen), 64'd1);
      check($sformatf("b2b%0d_latency", i), 64'(n), 64'(exp_lat(pb[i])));
      check($sformatf("b2b%0d_product", i), product, pp[i]);
    end
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("b2b_done_count", 64'(done_cnt - d0), 64'(NB));

    // Reset during step 15 aborts without a done pulse.
    wait_ready("rst_mid");
    a = 32'hDEADBEEF; b = 32'h12345678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) @(posedge clk);
    #1;
    check("rst_mid_busy", 64'(busy), 64'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    check("rst_mid_ready", 64'(ready), 64'd1);
    check("rst_mid_busy0", 64'(busy), 64'd0);
    check("rst_mid_product", product, 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    check("rst_mid_no_done", 64'(done_cnt - d0), 64'd0);
    check("rst_mid_idle", 64'(ready), 64'd1);
    check("rst_mid_product_hold", product, 64'd0);

    run_op(32'd10, 32'd10, 64'd100, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
